// File: rtl/mmc1_pkg.sv
// mmc1_pkg: shared MMC1 types and reset constants
package mmc1_pkg;
  typedef enum logic [1:0] {MIR_ONE_LO, MIR_ONE_HI, MIR_VERT, MIR_HORIZ} mirror_t;
  typedef enum logic [1:0] {PRG_32K_A, PRG_32K_B, PRG_FIX_FIRST, PRG_FIX_LAST} prg_mode_t;
  typedef struct packed {
    logic [4:0] ctrl;
    logic [4:0] chr0;
    logic [4:0] chr1;
    logic [4:0] prg;
  } mmc1_regs_t;
  localparam logic [4:0] CTRL_RST    = 5'h0C;
  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
endpackage

// File: rtl/mmc1_mapper_if.sv
// mmc1_mapper_if: cart CPU/PPU bus view and the mapped PRG/CHR/CIRAM outputs
interface mmc1_mapper_if;
  logic        m2;
  logic        cpu_rw;
  logic        romsel;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [13:0] ppu_addr;
  logic [17:0] prg_addr;
  logic [16:0] chr_addr;
  logic        ciram_a10;
  logic        prg_ram_ce;
  modport master (output m2, cpu_rw, romsel, cpu_addr, cpu_data, ppu_addr,
                  input prg_addr, chr_addr, ciram_a10, prg_ram_ce);
  modport slave  (input m2, cpu_rw, romsel, cpu_addr, cpu_data, ppu_addr,
                  output prg_addr, chr_addr, ciram_a10, prg_ram_ce);
endinterface

// File: rtl/m2_sampler.sv
// m2_sampler: synchronises async M2 and emits one strobe WR_SAMPLE clocks after its rise,
// unless M2 falls first.
module m2_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int WR_SAMPLE   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_m2,
  output logic o_strobe,
  output logic o_m2_sync
);
  localparam int CW = $clog2(WR_SAMPLE + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_m2_prev;
  logic [CW-1:0]          r_cnt;
  assign o_m2_sync = r_sync[SYNC_STAGES-1];
  assign o_strobe  = o_m2_sync && r_cnt == CW'(WR_SAMPLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync    <= '0;
      r_m2_prev <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_m2};
      r_m2_prev <= o_m2_sync;
      r_cnt     <= (o_m2_sync && !r_m2_prev) ? CW'(1) :
                   (!o_m2_sync || o_strobe || r_cnt == '0) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/mmc1_mapper.sv
// mmc1_mapper: MMC1 serial register capture and PRG/CHR/CIRAM address decode.
// Define MMC1_PRG_RAM_EN to enable the $6000-$7FFF PRG-RAM select.
module mmc1_mapper
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WR_SAMPLE   = 4
) (
  input logic           clk,
  input logic           rst,
  mmc1_mapper_if.slave  bus
);
  mmc1_regs_t r_regs, w_regs_nxt;
  logic [4:0] r_shift, w_shift_nxt, w_val;
  logic       r_prev_wr, w_strobe, w_m2_sync, w_wr, w_a14, w_unused;
  prg_mode_t  w_pmode;
  mirror_t    w_mir;
  m2_sampler #(.SYNC_STAGES(SYNC_STAGES), .WR_SAMPLE(WR_SAMPLE)) u_sampler (
    .clk(clk), .rst(rst), .i_m2(bus.m2), .o_strobe(w_strobe), .o_m2_sync(w_m2_sync)
  );
  assign w_wr  = w_strobe && !bus.romsel && !bus.cpu_rw;
  assign w_val = {bus.cpu_data[0], r_shift[4:1]};
  // The sentinel bit reaching shift[0] marks the fifth bit of a serial load
  always_comb begin
    w_regs_nxt  = r_regs;
    w_shift_nxt = r_shift;
    if (w_wr && !r_prev_wr) begin
      if (bus.cpu_data[7]) begin
        w_shift_nxt     = SHIFT_EMPTY;
        w_regs_nxt.ctrl = r_regs.ctrl | CTRL_RST;
      end else if (r_shift[0]) begin
        w_shift_nxt = SHIFT_EMPTY;
        case (bus.cpu_addr[14:13])
          2'b00:   w_regs_nxt.ctrl = w_val;
          2'b01:   w_regs_nxt.chr0 = w_val;
          2'b10:   w_regs_nxt.chr1 = w_val;
          default: w_regs_nxt.prg  = w_val;
        endcase
      end else begin
        w_shift_nxt = w_val;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_regs    <= '{ctrl: CTRL_RST, chr0: 5'h0, chr1: 5'h0, prg: 5'h0};
      r_shift   <= SHIFT_EMPTY;
      r_prev_wr <= 1'b0;
    end else begin
      r_regs  <= w_regs_nxt;
      r_shift <= w_shift_nxt;
      if (w_strobe) r_prev_wr <= w_wr;
    end
  assign w_pmode = prg_mode_t'(r_regs.ctrl[3:2]);
  assign w_mir   = mirror_t'(r_regs.ctrl[1:0]);
  assign w_a14   = bus.cpu_addr[14];
  assign bus.prg_addr =
    (w_pmode == PRG_FIX_LAST)  ? (w_a14 ? {4'hF, bus.cpu_addr[13:0]} : {r_regs.prg[3:0], bus.cpu_addr[13:0]}) :
    (w_pmode == PRG_FIX_FIRST) ? (w_a14 ? {r_regs.prg[3:0], bus.cpu_addr[13:0]} : {4'h0, bus.cpu_addr[13:0]}) :
                                 {r_regs.prg[3:1], bus.cpu_addr[14:0]};
  assign bus.chr_addr = r_regs.ctrl[4] ?
    {bus.ppu_addr[12] ? r_regs.chr1 : r_regs.chr0, bus.ppu_addr[11:0]} :
    {r_regs.chr0[4:1], bus.ppu_addr[12:0]};
  assign bus.ciram_a10 = (w_mir == MIR_VERT)  ? bus.ppu_addr[10] :
                         (w_mir == MIR_HORIZ) ? bus.ppu_addr[11] : (w_mir == MIR_ONE_HI);
`ifdef MMC1_PRG_RAM_EN
  assign bus.prg_ram_ce = w_m2_sync && bus.romsel && bus.cpu_addr[14:13] == 2'b11 && !r_regs.prg[4];
  assign w_unused = &{1'b0, bus.cpu_data[6:1], bus.ppu_addr[13]};
`else
  assign bus.prg_ram_ce = 1'b0;
  assign w_unused = &{1'b0, bus.cpu_data[6:1], bus.ppu_addr[13], r_regs.prg[4], w_m2_sync};
`endif
endmodule

// File: tb/tb_mmc1_mapper.sv
// tb_mmc1_mapper: table vectors, directed MMC1 sequences and randomized bus cycles vs a register-level model
module tb_mmc1_mapper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mmc1_mapper_if bif();
  mmc1_mapper dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] m_ctrl, m_chr0, m_chr1, m_prg, m_acc;
  int   m_cnt;
  logic m_prev;

  typedef struct {
    logic [14:0] ca;
    logic [13:0] pa;
    logic [17:0] ep;
    logic [16:0] ec;
    logic        ea;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = 5'h0C; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
    m_acc = 0; m_cnt = 0; m_prev = 0;
  endtask

  // Serial load modelled as a bit counter and accumulator
  task automatic m_bus(input logic rw, input logic rs, input logic [14:0] a, input logic [7:0] d);
    logic wr;
    wr = !rs && !rw;
    if (wr && !m_prev) begin
      if (d[7]) begin
        m_cnt = 0; m_acc = 0; m_ctrl = m_ctrl | 5'h0C;
      end else begin
        m_acc[m_cnt] = d[0];
        m_cnt++;
        if (m_cnt == 5) begin
          case (a[14:13])
            2'd0: m_ctrl = m_acc;
            2'd1: m_chr0 = m_acc;
            2'd2: m_chr1 = m_acc;
            default: m_prg = m_acc;
          endcase
          m_cnt = 0; m_acc = 0;
        end
      end
    end
    m_prev = wr;
  endtask

  function automatic logic [17:0] exp_prg(input logic [14:0] a);
    int mode, off, bank;
    mode = (int'(m_ctrl) / 4) % 4;
    off  = int'(a) % 16384;
    bank = int'(m_prg) % 16;
    if (mode < 2) return 18'((bank / 2) * 32768 + int'(a));
    if (mode == 2) return 18'((a >= 15'd16384) ? bank * 16384 + off : off);
    return 18'((a >= 15'd16384) ? 15 * 16384 + off : bank * 16384 + off);
  endfunction

  function automatic logic [16:0] exp_chr(input logic [13:0] p);
    int lo;
    lo = int'(p) % 8192;
    if (m_ctrl < 5'd16) return 17'((int'(m_chr0) / 2) * 8192 + lo);
    return 17'(((lo >= 4096) ? int'(m_chr1) : int'(m_chr0)) * 4096 + lo % 4096);
  endfunction

  function automatic logic exp_cir(input logic [13:0] p);
    case (int'(m_ctrl) % 4)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'((int'(p) / 1024) % 2);
      default: return 1'((int'(p) / 2048) % 2);
    endcase
  endfunction

  task automatic bus(input logic rw, input logic rs, input logic [14:0] a, input logic [7:0] d, input int hi);
    @(negedge clk);
    bif.cpu_rw = rw; bif.romsel = rs; bif.cpu_addr = a; bif.cpu_data = d;
    @(negedge clk);
    bif.m2 = 1'b1;
    repeat (hi) @(negedge clk);
    bif.m2 = 1'b0;
    repeat (6) @(negedge clk);
    if (hi >= 8) m_bus(rw, rs, a, d);
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 1'b0, {sel, 13'h0}, {7'h0, v[i]}, 10);
      bus(1'b1, 1'b0, {sel, 13'h0}, 8'h00, 10);
    end
  endtask

  task automatic probe(input logic [14:0] ca, input logic [13:0] pa);
    @(negedge clk);
    bif.cpu_addr = ca; bif.ppu_addr = pa;
    #1;
    chk("prg_addr", 32'(bif.prg_addr), 32'(exp_prg(ca)));
    chk("chr_addr", 32'(bif.chr_addr), 32'(exp_chr(pa)));
    chk("ciram_a10", 32'(bif.ciram_a10), 32'(exp_cir(pa)));
  endtask

  initial begin
    bif.m2 = 0; bif.cpu_rw = 1; bif.romsel = 1; bif.cpu_addr = 0; bif.cpu_data = 0; bif.ppu_addr = 0;
    m_reset();
    tbl[0] = '{15'h4123, 14'h0000, 18'h3C123, 17'h00000, 1'b0};
    tbl[1] = '{15'h0005, 14'h1FFF, 18'h00005, 17'h01FFF, 1'b0};
    tbl[2] = '{15'h7FFF, 14'h3ABC, 18'h3FFFF, 17'h01ABC, 1'b0};
    tbl[3] = '{15'h3FFF, 14'h0400, 18'h03FFF, 17'h00400, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bif.cpu_addr = tbl[i].ca; bif.ppu_addr = tbl[i].pa;
      #1;
      chk("rst_prg", 32'(bif.prg_addr), 32'(tbl[i].ep));
      chk("rst_chr", 32'(bif.chr_addr), 32'(tbl[i].ec));
      chk("rst_ciram", 32'(bif.ciram_a10), 32'(tbl[i].ea));
    end
    // Five-bit load of prg=5
    write_reg(2'd3, 5'h05);
    probe(15'h0010, 14'h0000);
    chk("prg5_addr", 32'(bif.prg_addr), 32'h14010);
    // Back-to-back writes: the second must be dropped
    bus(1'b0, 1'b0, 15'h6000, 8'h01, 10);
    bus(1'b0, 1'b0, 15'h6000, 8'h00, 10);
    bus(1'b1, 1'b0, 15'h6000, 8'h00, 10);
    foreach (tbl[i]) begin
      bus(1'b0, 1'b0, 15'h6000, {7'h0, (i < 2) ? 1'b1 : 1'b0}, 10);
      bus(1'b1, 1'b0, 15'h6000, 8'h00, 10);
    end
    probe(15'h0000, 14'h0000);
    chk("rmw_prg", 32'(bif.prg_addr), 32'h1C000);
    // Chr mode 1, vertical mirroring
    write_reg(2'd0, 5'h12);
    write_reg(2'd2, 5'h07);
    probe(15'h4000, 14'h1400);
    chk("chr1_addr", 32'(bif.chr_addr), 32'h07400);
    chk("vert_ciram", 32'(bif.ciram_a10), 32'h1);
    chk("mode0_prg", 32'(bif.prg_addr), 32'h1C000);
    // Partial load aborted by a bit-7 write
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, 1'b0, 15'h2000, 8'h01, 10);
      bus(1'b1, 1'b0, 15'h2000, 8'h00, 10);
    end
    bus(1'b0, 1'b0, 15'h2000, 8'h80, 10);
    bus(1'b1, 1'b0, 15'h2000, 8'h00, 10);
    probe(15'h4000, 14'h0000);
    chr_reset_check: chk("abort_prg", 32'(bif.prg_addr), 32'h3C000);
    write_reg(2'd1, 5'h03);
    probe(15'h0000, 14'h0400);
    chk("chr0_addr", 32'(bif.chr_addr), 32'h03400);
    probe(15'h0000, 14'h1000);
    chk("chr1_kept", 32'(bif.chr_addr), 32'h07000);
    // Short M2 pulses never sample
    bus(1'b0, 1'b0, 15'h6000, 8'h01, 2);
    bus(1'b0, 1'b0, 15'h6000, 8'h01, 2);
    write_reg(2'd3, 5'h02);
    probe(15'h0000, 14'h0000);
    chk("short_m2", 32'(bif.prg_addr), 32'h08000);
    // PRG-RAM select during a $6000 access
    @(negedge clk);
    bif.cpu_rw = 1; bif.romsel = 1; bif.cpu_addr = 15'h6000;
    @(negedge clk);
    bif.m2 = 1'b1;
    repeat (6) @(negedge clk);
`ifdef MMC1_PRG_RAM_EN
    chk("prg_ram_ce", 32'(bif.prg_ram_ce), 32'(!m_prg[4]));
`else
    chk("prg_ram_ce", 32'(bif.prg_ram_ce), 32'h0);
`endif
    bif.m2 = 1'b0;
    repeat (6) @(negedge clk);
    m_bus(1'b1, 1'b1, 15'h6000, 8'h00);
    // Reset mid-sequence discards partial shift bits
    bus(1'b0, 1'b0, 15'h6000, 8'h01, 10);
    bus(1'b1, 1'b0, 15'h6000, 8'h00, 10);
    bus(1'b0, 1'b0, 15'h6000, 8'h01, 10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
    probe(15'h4123, 14'h0000);
    chk("rst_mid", 32'(bif.prg_addr), 32'h3C123);
    write_reg(2'd3, 5'h09);
    probe(15'h0001, 14'h0000);
    chk("rst_reload", 32'(bif.prg_addr), 32'h24001);
    // Randomized bus traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic rw, rs;
      logic [7:0] d;
      rw = ($urandom % 3) == 0;
      rs = ($urandom % 4) == 0;
      d  = ($urandom % 10 == 0) ? 8'(8'h80 | $urandom) : 8'($urandom % 128);
      bus(rw, rs, 15'($urandom), d, ($urandom % 20 == 0) ? 2 : 10);
      probe(15'($urandom), 14'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
